alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Arbiter/sequencer that time-shares one 32-bit combinational ALU between two requesters (e.g. EX-stage issue and a branch/address helper). It accepts one operation at a time via valid/ready, round-robins between requesters, and drives registered A/B/OP into the ALU. It captures F plus CF/OF/SF/PF/ZF and returns them on a single tagged response channel with backpressure.

Parameters:
SIZE, 32, datapath width of operands and result (matches ALU width)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  4  ALU opcode (AND=0, OR=1, ADD=2, XOR=3, NOR=4, SLL=5, SUB=6, SLT=7)
req0_a  input  SIZE  operand A
req0_b  input  SIZE  operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
alu_a  output  SIZE  registered operand A to ALU
alu_b  output  SIZE  registered operand B to ALU
alu_op  output  4  registered opcode to ALU
alu_f  input  SIZE  ALU result
alu_cf, alu_of, alu_sf, alu_pf, alu_zf  input  1 each  ALU flags
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester index of response
rsp_f  output  SIZE  captured result
rsp_flags  output  5  captured flags {OF,SF,PF,ZF,CF} (bit4..bit0)
rsp_err  output  1  illegal opcode (only with optional feature; else tied 0)
busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant = req0 if only req0_valid; req1 if only req1_valid; if both, requester != last_grant. reqN_ready = (state==IDLE) && grant==N && reqN_valid (combinational; valid must not depend on ready). On accept: latch op/a/b into alu_op/alu_a/alu_b, latch rsp_id, update last_grant, go to EXEC.
- EXEC (one cycle): ALU inputs stable; at cycle end capture alu_f into rsp_f and flags into rsp_flags; go to RESP.
- RESP: rsp_valid=1; rsp_f/rsp_flags/rsp_id stable until rsp_ready sampled high; then go to IDLE next cycle. No new accept while in RESP (no accept in the same cycle as rsp handshake).
- Latency: accept at cycle T -> rsp_valid at T+2. Min issue interval 3 cycles.
- alu_a/alu_b/alu_op hold last issued values outside EXEC (no toggling).
- Flags passed raw; CF/OF meaningful only for ADD/SUB; controller does no interpretation.
- Reset: state=IDLE, last_grant=1 (req0 wins first tie), alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_flags=0, rsp_err=0, busy=0, both ready=0.
- Reset mid-operation (EXEC or RESP): in-flight op dropped, no response issued, state to IDLE next cycle.
- Requester dropping valid before ready: no accept, no state change.
- rsp_ready high while rsp_valid low: ignored.

Optional Feature:
ALU_SHARE_OPCHK_EN: when defined, op[3]==1 is illegal: op accepted normally, ALU not reissued (alu_* keep previous values), FSM goes IDLE->RESP via EXEC with rsp_f=0, rsp_flags=0, rsp_err=1. When undefined, op forwarded unchanged (ALU decodes op[2:0] only) and rsp_err is constant 0.

Test Plan:
- After reset, req0 ADD a=5 b=7 -> req0_ready at T, alu_op=2 at T+1, rsp_valid at T+2 with rsp_id=0, rsp_f=0x0000000C, rsp_flags=5'b00100.
- req1 SUB a=3 b=3, rsp_ready=1 -> rsp_id=1, rsp_f=0, ZF=1, PF=1 at T+2; busy low at T+3.
- req0 and req1 both valid continuously (AND 0xF0/0x3C, OR 0x01/0x02) -> grants alternate 0,1,0,1 starting with 0; responses 0x30, 0x03 in that order.
- rsp_ready held low 4 cycles after rsp_valid -> rsp_f/rsp_flags/rsp_id stable, both ready low, no new accept until handshake.
- rst asserted in EXEC of SLT a=0xFFFFFFFF b=1 -> no rsp_valid, all outputs at reset values next cycle, next req0 accepted normally.
- With ALU_SHARE_OPCHK_EN, req0 op=4'b1000 -> rsp_err=1, rsp_f=0, alu_op unchanged; without macro, rsp_err stays 0.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// ============================================================================
// Module   : alu_share_ctrl_if
// Desc     : Requester, ALU and response signal bundle for alu_share_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface alu_share_ctrl_if #(
    parameter int SIZE = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [3:0]      req0_op;
    logic [SIZE-1:0] req0_a;
    logic [SIZE-1:0] req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [3:0]      req1_op;
    logic [SIZE-1:0] req1_a;
    logic [SIZE-1:0] req1_b;

    logic [SIZE-1:0] alu_a;
    logic [SIZE-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [SIZE-1:0] alu_f;
    logic            alu_cf;
    logic            alu_of;
    logic            alu_sf;
    logic            alu_pf;
    logic            alu_zf;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [SIZE-1:0] rsp_f;
    logic [4:0]      rsp_flags;
    logic            rsp_err;
    logic            busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_f, alu_cf, alu_of, alu_sf, alu_pf, alu_zf,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_f, rsp_flags, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_f, alu_cf, alu_of, alu_sf, alu_pf, alu_zf,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_f, rsp_flags, rsp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ============================================================================
// Module   : alu_share_ctrl
// Desc     : Round-robin sequencer sharing one combinational ALU between two
//            requesters. Optional macro ALU_SHARE_OPCHK_EN flags op[3] illegal.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_share_ctrl #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_rsp_id;
    logic [SIZE-1:0] r_alu_a;
    logic [SIZE-1:0] r_alu_b;
    logic [3:0]      r_alu_op;
    logic [SIZE-1:0] r_rsp_f;
    logic [4:0]      r_rsp_flags;

    logic            w_grant;
    logic            w_idle;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_accept;
    logic [3:0]      w_sel_op;
    logic [SIZE-1:0] w_sel_a;
    logic [SIZE-1:0] w_sel_b;

    // On a tie the requester that did not win last time is granted
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle   = (r_state == S_IDLE);
    assign w_ready0 = w_idle && !w_grant && bus.req0_valid;
    assign w_ready1 = w_idle &&  w_grant && bus.req1_valid;
    assign w_accept = w_ready0 || w_ready1;
    assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;
    assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ALU_SHARE_OPCHK_EN
    logic r_err_pend;
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pend <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err_pend <= w_sel_op[3];
            end
            if (r_state == S_EXEC) begin
                r_rsp_err <= r_err_pend;
            end
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    logic r_err_pend;
    assign r_err_pend  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= 4'd0;
            r_rsp_f      <= '0;
            r_rsp_flags  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_rsp_id     <= w_grant;
`ifdef ALU_SHARE_OPCHK_EN
                // Illegal ops leave the ALU inputs untouched
                if (!w_sel_op[3]) begin
                    r_alu_a  <= w_sel_a;
                    r_alu_b  <= w_sel_b;
                    r_alu_op <= w_sel_op;
                end
`else
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
`endif
            end
            if (r_state == S_EXEC) begin
                if (r_err_pend) begin
                    r_rsp_f     <= '0;
                    r_rsp_flags <= 5'd0;
                end else begin
                    r_rsp_f     <= bus.alu_f;
                    r_rsp_flags <= {bus.alu_of, bus.alu_sf, bus.alu_pf,
                                    bus.alu_zf, bus.alu_cf};
                end
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_f      = r_rsp_f;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.busy       = !w_idle;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// ============================================================================
// Module   : tb_alu_share_ctrl
// Desc     : Scoreboard bench for alu_share_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_share_ctrl;
    localparam int SIZE = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.SIZE(SIZE)) bus();

    alu_share_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] f;
        logic [4:0]  flags;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t m_exp;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Returns {OF,SF,PF,ZF,CF,F}; PF is even parity, CF on SUB is borrow
    function automatic logic [36:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] f;
        logic        cf;
        logic        of;
        s  = '0;
        f  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (op[2:0])
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                f  = s[31:0];
                cf = s[32];
                of = (a[31] == b[31]) && (f[31] != a[31]);
            end
            3'd3: f = a ^ b;
            3'd4: f = ~(a | b);
            3'd5: f = a << b[4:0];
            3'd6: begin
                f  = a - b;
                cf = (a < b);
                of = (a[31] != b[31]) && (f[31] != a[31]);
            end
            default: f = {31'd0, ($signed(a) < $signed(b))};
        endcase
        return {of, f[31], ~^f, (f == 32'd0), cf, f};
    endfunction

    logic [36:0] w_alu;
    assign w_alu     = alu_calc(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_f = w_alu[31:0];
    assign {bus.alu_of, bus.alu_sf, bus.alu_pf, bus.alu_zf, bus.alu_cf} = w_alu[36:32];

    function automatic rsp_t expect_rsp(input logic id, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
        rsp_t        r;
        logic [36:0] v;
        v       = alu_calc(op, a, b);
        r.id    = id;
        r.f     = v[31:0];
        r.flags = v[36:32];
        r.err   = 1'b0;
`ifdef ALU_SHARE_OPCHK_EN
        if (op[3]) begin
            r.f     = '0;
            r.flags = '0;
            r.err   = 1'b1;
        end
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            chk("rsp_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                m_exp = sb.pop_front();
                chk("rsp_id", bus.rsp_id, m_exp.id);
                chk("rsp_f", bus.rsp_f, m_exp.f);
                chk("rsp_flags", bus.rsp_flags, m_exp.flags);
                chk("rsp_err", bus.rsp_err, m_exp.err);
            end
        end
    end

    task automatic wait_accept(output logic id);
        logic seen;
        seen = 1'b0;
        id   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("accept_seen", seen, 1);
        if (seen) begin
            chk("single_grant", (bus.req0_ready && bus.req1_ready), 0);
            id = bus.req1_ready;
            if (id) sb.push_back(expect_rsp(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
            else    sb.push_back(expect_rsp(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
        end
    endtask

    task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic g;
        @(posedge clk); #1;
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        wait_accept(g);
        chk("issue_grant", g, id);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.rsp_valid) break;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic g;
        bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_f", bus.rsp_f, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;

        // ADD 5+7 from requester 0
        issue(1'b0, 4'd2, 32'd5, 32'd7);
        @(negedge clk);
        chk("add_alu_op", bus.alu_op, 2);
        chk("add_alu_a", bus.alu_a, 5);
        chk("add_busy", bus.busy, 1);
        chk("add_early_valid", bus.rsp_valid, 0);
        @(negedge clk);
        chk("add_rsp_valid", bus.rsp_valid, 1);
        chk("add_rsp_id", bus.rsp_id, 0);
        chk("add_rsp_f", bus.rsp_f, 32'h0000_000C);
        chk("add_rsp_flags", bus.rsp_flags, 5'b00100);
        drain();

        // SUB 3-3 from requester 1
        issue(1'b1, 4'd6, 32'd3, 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("sub_rsp_valid", bus.rsp_valid, 1);
        chk("sub_rsp_id", bus.rsp_id, 1);
        chk("sub_rsp_f", bus.rsp_f, 0);
        chk("sub_zf_pf", {bus.rsp_flags[2], bus.rsp_flags[1]}, 2'b11);
        @(negedge clk);
        chk("sub_busy_after", bus.busy, 0);
        drain();

        // Both requesters valid continuously
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 32'hF0; bus.req0_b = 32'h3C;
        bus.req1_valid = 1'b1; bus.req1_op = 4'd1; bus.req1_a = 32'h01; bus.req1_b = 32'h02;
        for (int i = 0; i < 4; i++) begin
            wait_accept(g);
            chk("alt_grant", g, i % 2);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        // Response backpressure with both requesters waiting
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        bus.req0_valid = 1'b1; bus.req0_op = 4'd4; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b1; bus.req1_op = 4'd5; bus.req1_a = 32'd1; bus.req1_b = 32'd4;
        @(negedge clk);
        chk("exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_f", bus.rsp_f, 32'hAAAA_AAAA);
            chk("bp_rsp_flags", bus.rsp_flags, 5'b01100);
            chk("bp_rsp_id", bus.rsp_id, 0);
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_accept(g);
        chk("bp_next_grant", g, 1);
        wait_accept(g);
        chk("bp_then_grant", g, 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        // Signed compare through the normal path
        issue(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
        drain();

        // Reset while SLT is in EXEC
        issue(1'b0, 4'd7, 32'hFFFF_FFFF, 32'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_alu_op", bus.alu_op, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        chk("mid_rst_alu_b", bus.alu_b, 0);
        chk("mid_rst_rsp_f", bus.rsp_f, 0);
        chk("mid_rst_rsp_id", bus.rsp_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.rsp_valid, 0);
        end
        issue(1'b0, 4'd2, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("ovf_rsp_flags", bus.rsp_flags, 5'b11000);
        drain();

        // Opcode with bit 3 set
        issue(1'b0, 4'b1000, 32'h1234_5678, 32'h0000_00FF);
        @(negedge clk);
`ifdef ALU_SHARE_OPCHK_EN
        chk("ill_alu_op", bus.alu_op, 2);
        chk("ill_alu_a", bus.alu_a, 32'h7FFF_FFFF);
`else
        chk("ill_alu_op", bus.alu_op, 4'b1000);
        chk("ill_alu_a", bus.alu_a, 32'h1234_5678);
`endif
        @(negedge clk);
`ifdef ALU_SHARE_OPCHK_EN
        chk("ill_rsp_err", bus.rsp_err, 1);
        chk("ill_rsp_f", bus.rsp_f, 0);
`else
        chk("ill_rsp_err", bus.rsp_err, 0);
        chk("ill_rsp_f", bus.rsp_f, 32'h78);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
